// File: rtl/pic_core_n.sv
// 8259-style programmable interrupt controller: synchronised request lines,
// IRR/IMR/ISR with fixed or rotating priority and a registered acknowledge.
module pic_core_n #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [2:0]         addr,
    input  logic [NUM_IRQ-1:0] wdata,
    output logic [NUM_IRQ-1:0] rdata,
    output logic               int_o,
    input  logic               inta,
    output logic               vec_valid,
    output logic [VEC_W-1:0]   vector,
    output logic               spurious
);
    localparam int IDX_W  = $clog2(NUM_IRQ);
    localparam int RANK_W = IDX_W + 1;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_IMR   = 3'd1;
    localparam logic [2:0] A_IRR   = 3'd2;
    localparam logic [2:0] A_ISR   = 3'd3;
    localparam logic [2:0] A_VBASE = 3'd4;
    localparam logic [2:0] A_NSEOI = 3'd5;
    localparam logic [2:0] A_SEOI  = 3'd6;
    localparam logic [2:0] A_SETLP = 3'd7;

    logic [NUM_IRQ-1:0] s1_q, s2_q, prev_q;
    logic [NUM_IRQ-1:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [VEC_W-1:0]   vbase_q, vbase_d;
    logic [IDX_W-1:0]   lp_q, lp_d;
    logic [NUM_IRQ-1:0] rdata_q, rdata_d;
    logic               int_q, int_d;
    logic               vv_q, vv_d, spur_q, spur_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               ackp_q, ackp_d, acks_q, acks_d;
    logic [IDX_W-1:0]   ackw_q, ackw_d;

    // Rank of the highest-priority set bit, counted from lp+1; NUM_IRQ when empty.
    function automatic logic [RANK_W-1:0] top_rank(input logic [NUM_IRQ-1:0] v,
                                                   input logic [IDX_W-1:0] lp);
        logic [RANK_W-1:0] r;
        int j;
        r = RANK_W'(NUM_IRQ);
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            j = (int'(lp) + 1 + k) % NUM_IRQ;
            if (v[j[IDX_W-1:0]]) r = RANK_W'(k);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] rank_idx(input logic [RANK_W-1:0] r,
                                                  input logic [IDX_W-1:0] lp);
        int j;
        j = (int'(lp) + 1 + int'(r)) % NUM_IRQ;
        return j[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic               ltim, aeoi, rotate, en;
    logic [NUM_IRQ-1:0] pend, ack_mask, eoi_clr, rd_val;
    logic [RANK_W-1:0]  pend_rank, isr_rank;
    logic [IDX_W-1:0]   win_idx, isr_top, wr_idx;
    logic               wr_idx_ok, ack_apply;

    assign ltim      = ctrl_q[0];
    assign aeoi      = ctrl_q[1];
    assign rotate    = ctrl_q[2];
    assign en        = ctrl_q[3];
    assign pend      = irr_q & ~imr_q;
    assign pend_rank = top_rank(pend, lp_q);
    assign isr_rank  = top_rank(isr_q, lp_q);
    assign win_idx   = rank_idx(pend_rank, lp_q);
    assign isr_top   = rank_idx(isr_rank, lp_q);
    assign wr_idx    = wdata[IDX_W-1:0];
    assign wr_idx_ok = int'(wr_idx) < NUM_IRQ;
    assign ack_apply = ackp_q & ~acks_q;

    always_comb begin
        imr_d    = imr_q;
        ctrl_d   = ctrl_q;
        vbase_d  = vbase_q;
        lp_d     = lp_q;
        rdata_d  = rdata_q;
        vector_d = vector_q;
        ackw_d   = ackw_q;
        acks_d   = acks_q;
        eoi_clr  = '0;
        rd_val   = '0;

        // Stage 1 of the acknowledge: latch winner from pre-update state.
        ackp_d = inta & ~ackp_q;
        if (inta && !ackp_q) begin
            ackw_d = win_idx;
            acks_d = ~(en & (|pend));
        end
        // Stage 2: present the vector and commit IRR/ISR/lp effects.
        vv_d     = ackp_q;
        spur_d   = ackp_q & acks_q;
        ack_mask = ack_apply ? onehot(ackw_q) : '0;
        if (ackp_q)
            vector_d = {vbase_q[VEC_W-1:IDX_W], acks_q ? IDX_W'(NUM_IRQ - 1) : ackw_q};
        if (ack_apply && aeoi && rotate) lp_d = ackw_q;

        if (wr_en) begin
            case (addr)
                A_CTRL:  ctrl_d  = wdata[3:0];
                A_IMR:   imr_d   = wdata;
                A_VBASE: vbase_d = wdata[VEC_W-1:0];
                A_NSEOI: if (|isr_q) begin
                    eoi_clr = onehot(isr_top);
                    if (rotate) lp_d = isr_top;
                end
                A_SEOI:  if (wr_idx_ok) eoi_clr = onehot(wr_idx);
                A_SETLP: if (wr_idx_ok) lp_d = wr_idx;
                default: ;
            endcase
        end

        isr_d = (isr_q & ~eoi_clr) | (aeoi ? '0 : ack_mask);
        irr_d = ltim ? s2_q : ((irr_q & ~ack_mask) | (s2_q & ~prev_q));
        if (wr_en && addr == A_CTRL && wdata[0] != ltim) irr_d = '0;

        if (rd_en) begin
            case (addr)
                A_CTRL:  rd_val[3:0] = ctrl_q;
                A_IMR:   rd_val = imr_q;
                A_IRR:   rd_val = irr_q;
                A_ISR:   rd_val = isr_q;
                A_VBASE: rd_val[VEC_W-1:0] = vbase_q;
                default: rd_val = '0;
            endcase
            rdata_d = rd_val;
        end

        // Held low while an ack is in flight so it reflects the committed state.
        int_d = en & (pend_rank < isr_rank) & ~ackp_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            irr_q    <= '0;
            imr_q    <= '1;
            isr_q    <= '0;
            ctrl_q   <= '0;
            vbase_q  <= '0;
            lp_q     <= IDX_W'(NUM_IRQ - 1);
            rdata_q  <= '0;
            int_q    <= 1'b0;
            vv_q     <= 1'b0;
            spur_q   <= 1'b0;
            vector_q <= '0;
            ackp_q   <= 1'b0;
            acks_q   <= 1'b0;
            ackw_q   <= '0;
        end else begin
            s1_q     <= irq_in;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            irr_q    <= irr_d;
            imr_q    <= imr_d;
            isr_q    <= isr_d;
            ctrl_q   <= ctrl_d;
            vbase_q  <= vbase_d;
            lp_q     <= lp_d;
            rdata_q  <= rdata_d;
            int_q    <= int_d;
            vv_q     <= vv_d;
            spur_q   <= spur_d;
            vector_q <= vector_d;
            ackp_q   <= ackp_d;
            acks_q   <= acks_d;
            ackw_q   <= ackw_d;
        end
    end

    assign rdata     = rdata_q;
    assign int_o     = int_q;
    assign vec_valid = vv_q;
    assign vector    = vector_q;
    assign spurious  = spur_q;

endmodule

// File: tb/tb_pic_core_n.sv
// Scenario bench for pic_core_n: an 8-channel and a 16-channel instance, with
// per-instance vector scoreboards checked whenever vec_valid pulses.
module tb_pic_core_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset8 = 1'b0, wr8 = 1'b0, rd8 = 1'b0, inta8 = 1'b0;
    logic [7:0]  irq8 = '0, wdata8 = '0, rdata8;
    logic [2:0]  addr8 = '0;
    logic        int8, vv8, spur8;
    logic [7:0]  vec8;

    logic        reset16 = 1'b0, wr16 = 1'b0, rd16 = 1'b0, inta16 = 1'b0;
    logic [15:0] irq16 = '0, wdata16 = '0, rdata16;
    logic [2:0]  addr16 = '0;
    logic        int16, vv16, spur16;
    logic [7:0]  vec16;

    int errors = 0;
    int checks = 0;
    logic [8:0] q8[$];
    logic [8:0] q16[$];
    logic [8:0] exp8, exp16;

    pic_core_n #(.NUM_IRQ(8), .VEC_W(8)) dut8 (
        .clk(clk), .reset(reset8), .irq_in(irq8), .wr_en(wr8), .rd_en(rd8),
        .addr(addr8), .wdata(wdata8), .rdata(rdata8), .int_o(int8), .inta(inta8),
        .vec_valid(vv8), .vector(vec8), .spurious(spur8)
    );

    pic_core_n #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
        .clk(clk), .reset(reset16), .irq_in(irq16), .wr_en(wr16), .rd_en(rd16),
        .addr(addr16), .wdata(wdata16), .rdata(rdata16), .int_o(int16), .inta(inta16),
        .vec_valid(vv16), .vector(vec16), .spurious(spur16)
    );

    always @(negedge clk) begin
        if (vv8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL vec8_unexpected got=%h expected none", {spur8, vec8});
            end else begin
                exp8 = q8.pop_front();
                if ({spur8, vec8} !== exp8) begin
                    errors++;
                    $display("FAIL vec8 got={spur,vec}=%h expected=%h", {spur8, vec8}, exp8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (vv16 === 1'b1) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL vec16_unexpected got=%h expected none", {spur16, vec16});
            end else begin
                exp16 = q16.pop_front();
                if ({spur16, vec16} !== exp16) begin
                    errors++;
                    $display("FAIL vec16 got={spur,vec}=%h expected=%h", {spur16, vec16}, exp16);
                end
            end
        end
    end

    // All tasks are entered right after a falling edge and return on one.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input bit sel);
        if (sel) begin irq16 = '0; wr16 = 0; rd16 = 0; inta16 = 0; reset16 = 0; end
        else     begin irq8  = '0; wr8  = 0; rd8  = 0; inta8  = 0; reset8  = 0; end
        @(negedge clk);
        if (sel) reset16 = 1'b1; else reset8 = 1'b1;
    endtask

    task automatic reg_wr(input bit sel, input logic [2:0] a, input logic [15:0] d);
        if (sel) begin wr16 = 1; addr16 = a; wdata16 = d; end
        else     begin wr8  = 1; addr8  = a; wdata8  = d[7:0]; end
        @(negedge clk);
        wr8 = 0; wr16 = 0;
    endtask

    task automatic reg_rd(input bit sel, input logic [2:0] a, output logic [15:0] d);
        if (sel) begin rd16 = 1; addr16 = a; end
        else     begin rd8  = 1; addr8  = a; end
        @(negedge clk);
        rd8 = 0; rd16 = 0;
        d = sel ? rdata16 : {8'h00, rdata8};
    endtask

    task automatic config_pic(input bit sel, input logic [15:0] imr, input logic [7:0] vbase,
                              input logic [7:0] ctrl);
        reg_wr(sel, 3'd1, imr);
        reg_wr(sel, 3'd4, {8'h00, vbase});
        reg_wr(sel, 3'd0, {8'h00, ctrl});
    endtask

    task automatic do_ack(input bit sel, input logic [8:0] expv);
        logic v;
        if (sel) begin q16.push_back(expv); inta16 = 1; end
        else     begin q8.push_back(expv);  inta8  = 1; end
        @(negedge clk);
        inta8 = 0; inta16 = 0;
        @(negedge clk);
        v = sel ? vv16 : vv8;
        checks++;
        if (v !== 1'b1) begin errors++; $display("FAIL ack_latency sel=%0d vec_valid=%b expected=1", sel, v); end
    endtask

    task automatic test_reset();
        logic [15:0] r;
        checks++; if ({rdata8, int8, vv8, vec8, spur8} !== 19'd0) begin errors++;
            $display("FAIL reset_outputs got=%h expected=0", {rdata8, int8, vv8, vec8, spur8}); end
        reset8 = 1'b1; reset16 = 1'b1;
        reg_rd(0, 3'd1, r);
        checks++; if (r !== 16'h00FF) begin errors++; $display("FAIL reset_imr got=%h expected=00ff", r); end
        reg_rd(0, 3'd0, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got=%h expected=0", r); end
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_isr got=%h expected=0", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_irr got=%h expected=0", r); end
        wr8 = 1; rd8 = 1; addr8 = 3'd1; wdata8 = 8'h5A;
        @(negedge clk);
        wr8 = 0; rd8 = 0;
        checks++; if (rdata8 !== 8'hFF) begin errors++; $display("FAIL wr_rd_same_cycle got=%h expected=ff", rdata8); end
        reg_rd(0, 3'd1, r);
        checks++; if (r !== 16'h005A) begin errors++; $display("FAIL imr_writeback got=%h expected=005a", r); end
        reg_rd(0, 3'd7, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL wo_read got=%h expected=0", r); end
    endtask

    task automatic test_basic();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h00FE, 8'h40, 8'h08);
        irq8[0] = 1'b1;
        @(negedge clk);
        irq8[0] = 1'b0;
        tick(2);
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL basic_int_early got=%b expected=0", int8); end
        tick(1);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL basic_int_rise got=%b expected=1", int8); end
        do_ack(0, 9'h040);
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL basic_isr got=%h expected=0001", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL basic_irr got=%h expected=0", r); end
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL basic_int_after got=%b expected=0", int8); end
    endtask

    task automatic test_nested();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h0000, 8'h40, 8'h08);
        irq8 = 8'h28;
        @(negedge clk);
        irq8 = 8'h00;
        tick(3);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL nested_int got=%b expected=1", int8); end
        do_ack(0, 9'h043);
        tick(1);
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL nested_blocked got=%b expected=0", int8); end
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0008) begin errors++; $display("FAIL nested_isr got=%h expected=0008", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0020) begin errors++; $display("FAIL nested_irr got=%h expected=0020", r); end
        reg_wr(0, 3'd5, 16'h0000);
        tick(1);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL nested_after_eoi got=%b expected=1", int8); end
        do_ack(0, 9'h045);
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0020) begin errors++; $display("FAIL nested_isr2 got=%h expected=0020", r); end
    endtask

    task automatic test_rotate();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h0000, 8'h40, 8'h0F);
        irq8 = 8'hFF;
        tick(4);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL rotate_int got=%b expected=1", int8); end
        for (int i = 0; i < 9; i++) do_ack(0, {1'b0, 8'h40 + 8'(i % 8)});
        reg_wr(0, 3'd7, 16'h0004);
        do_ack(0, 9'h045);
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rotate_isr got=%h expected=0", r); end
        irq8 = 8'h00;
        tick(3);
    endtask

    task automatic test_spurious();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h00FF, 8'h40, 8'h08);
        irq8[1] = 1'b1;
        @(negedge clk);
        irq8[1] = 1'b0;
        tick(3);
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL spur_int got=%b expected=0", int8); end
        do_ack(0, 9'h147);
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL spur_isr got=%h expected=0", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL spur_irr got=%h expected=0002", r); end
    endtask

    task automatic test_level();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h0000, 8'h40, 8'h09);
        irq8 = 8'h04;
        tick(4);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL level_int got=%b expected=1", int8); end
        do_ack(0, 9'h042);
        tick(1);
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL level_in_service got=%b expected=0", int8); end
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL level_isr got=%h expected=0004", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL level_irr_held got=%h expected=0004", r); end
        reg_wr(0, 3'd6, 16'h0002);
        tick(1);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL level_reassert got=%b expected=1", int8); end
        irq8 = 8'h00;
        tick(3);
        checks++; if (int8 !== 1'b1) begin errors++; $display("FAIL level_drop_early got=%b expected=1", int8); end
        tick(1);
        checks++; if (int8 !== 1'b0) begin errors++; $display("FAIL level_drop got=%b expected=0", int8); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL level_irr_clear got=%h expected=0", r); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        do_reset(0);
        config_pic(0, 16'h0000, 8'h40, 8'h08);
        irq8 = 8'h12;
        @(negedge clk);
        irq8 = 8'h00;
        tick(3);
        q8.push_back(9'h041);
        inta8 = 1'b1;
        tick(2);
        inta8 = 1'b0;
        checks++; if (vv8 !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b expected=1", vv8); end
        tick(3);
        reg_rd(0, 3'd3, r);
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL b2b_isr got=%h expected=0002", r); end
        reg_rd(0, 3'd2, r);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL b2b_irr got=%h expected=0010", r); end
    endtask

    task automatic test_wide();
        logic [15:0] r;
        do_reset(1);
        config_pic(1, 16'h0000, 8'hA0, 8'h08);
        irq16[12] = 1'b1;
        @(negedge clk);
        irq16[12] = 1'b0;
        tick(3);
        checks++; if (int16 !== 1'b1) begin errors++; $display("FAIL wide_int got=%b expected=1", int16); end
        do_ack(1, 9'h0AC);
        reg_rd(1, 3'd3, r);
        checks++; if (r !== 16'h1000) begin errors++; $display("FAIL wide_isr got=%h expected=1000", r); end
        irq16[7] = 1'b1;
        @(negedge clk);
        irq16[7] = 1'b0;
        tick(3);
        checks++; if (int16 !== 1'b1) begin errors++; $display("FAIL wide_nest_int got=%b expected=1", int16); end
        inta16 = 1'b1;
        @(negedge clk);
        inta16 = 1'b0;
        reset16 = 1'b0;
        @(negedge clk);
        checks++; if ({vv16, int16} !== 2'b00) begin errors++; $display("FAIL abort_in_reset got=%b expected=00", {vv16, int16}); end
        reset16 = 1'b1;
        tick(2);
        checks++; if (vv16 !== 1'b0) begin errors++; $display("FAIL abort_no_valid got=%b expected=0", vv16); end
        reg_rd(1, 3'd1, r);
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL abort_imr got=%h expected=ffff", r); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_nested();
        test_rotate();
        test_spurious();
        test_level();
        test_back_to_back();
        test_wide();
        tick(3);
        checks++; if (q8.size() != 0) begin errors++; $display("FAIL q8_drained left=%0d expected=0", q8.size()); end
        checks++; if (q16.size() != 0) begin errors++; $display("FAIL q16_drained left=%0d expected=0", q16.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_core_n.md
Name: pic_core_n

Overview:
- Parametrised, fully synchronous programmable interrupt controller core. Next generation of the team's 8259-style core.
- Resolves NUM_IRQ request lines using mask, request and in-service registers, with fixed or rotating priority, edge or level trigger, normal or automatic EOI.
- Delivers a vector through a registered acknowledge handshake.
- Sits between peripheral IRQ lines and the CPU bus glue; the host programs it through a simple synchronous register port.

Parameters:
- NUM_IRQ, 8, number of request channels, range 8..32; also the register data width.
- VEC_W, 8, vector width, must be ≤ NUM_IRQ.
- IDX_W, clog2(NUM_IRQ), channel index width; local, derived, not overridable.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- irq_in  in  NUM_IRQ  asynchronous request lines
- wr_en  in  1  register write strobe, one cycle
- rd_en  in  1  register read strobe, one cycle
- addr  in  3  register address
- wdata  in  NUM_IRQ  write data
- rdata  out  NUM_IRQ  read data, registered
- int_o  out  1  interrupt request to CPU
- inta  in  1  acknowledge pulse from CPU, one cycle
- vec_valid  out  1  one-cycle pulse, vector valid
- vector  out  VEC_W  interrupt vector
- spurious  out  1  one-cycle pulse with vec_valid when no request was pending

Behaviour:
- Reset (reset=0, async):
  - rdata, int_o, vec_valid, vector, spurious = 0.
  - IMR = all ones; IRR = 0; ISR = 0; CTRL = 0; VBASE = 0; lowest-priority pointer lp = NUM_IRQ-1.
  - Sync and edge-detect flops = 0.
  - Reset asserted mid-handshake aborts it; no vec_valid is issued.
- Register map:
  - addr 0: CTRL, RW. Bit0 ltim (1 = level), bit1 aeoi, bit2 rotate, bit3 enable; other bits read 0.
  - addr 1: IMR, RW.
  - addr 2: IRR, RO.
  - addr 3: ISR, RO.
  - addr 4: VBASE, RW, low VEC_W bits.
  - addr 5: non-specific EOI, WO.
  - addr 6: specific EOI, WO, wdata[IDX_W-1:0].
  - addr 7: set lp, WO, wdata[IDX_W-1:0].
  - WO/unmapped reads return 0. rdata updates on the clock after rd_en and holds otherwise.
- Input path:
  - Two-flop synchroniser per line.
  - Edge mode: IRR bit set on a synced 0→1 transition.
  - Level mode: IRR bit = synced level, not latched.
  - An irq rise sampled at edge k sets IRR at edge k+2 and raises int_o at edge k+3.
- Priority:
  - Highest priority channel = (lp+1) mod NUM_IRQ, descending cyclically.
  - pend = IRR & ~IMR.
  - int_o registered = enable & (pend≠0) & (highest pend channel outranks highest ISR channel, or ISR=0). This is fully nested mode.
- Acknowledge:
  - inta sampled at edge j latches winner index w (pre-update IRR/IMR/ISR).
  - At edge j+1: vec_valid=1, vector = {VBASE[VEC_W-1:IDX_W], w}.
  - Edge mode clears IRR[w]. ISR[w] is set unless aeoi.
  - aeoi with rotate: lp = w.
  - int_o is re-evaluated from edge j+1 onward.
  - inta with pend=0 or enable=0: vector = {VBASE hi, NUM_IRQ-1 low bits}, spurious=1, no register change.
  - inta while vec_valid is pending is ignored.
- EOI:
  - Non-specific clears the highest-priority set ISR bit; with rotate, lp = that index. No effect when ISR=0.
  - Specific clears ISR[idx]; lp is unchanged.
  - Index ≥ NUM_IRQ is ignored for specific EOI and for set-lp.
- Simultaneous events:
  - A new edge on channel w in the same cycle as its IRR clear: set wins.
  - IMR write during inta: the ack uses the old IMR.
  - EOI and ack-set in the same cycle: clear applies, then set (the set bit survives).
  - Write and read in the same cycle: read returns the pre-write value.
  - CTRL ltim change clears IRR.

Test Plan:
- Reset, write IMR=0xFE, CTRL=0x08, VBASE=0x40. Pulse irq_in[0] → int_o high 3 clocks after sync sample; inta → next cycle vec_valid=1, vector=0x40, ISR=0x01, IRR=0x00.
- irq 3 and irq 5 together, fixed priority, IMR=0 → first ack vector=0x43. Nested: second int_o only after non-specific EOI, then vector=0x45.
- Rotate mode, 8 channels all pending, aeoi=1 → eight successive acks give 0,1,…,7 then wrap to 0; lp tracks the last served channel.
- inta with IMR=0xFF → vector=0x47, spurious=1, ISR unchanged at 0.
- Level mode: hold irq_in[2], ack, issue specific EOI idx 2 → int_o reasserts; drop the line → IRR[2]=0 after 2 clocks, int_o low.
- NUM_IRQ=16, VEC_W=8, VBASE=0xA0 → irq 12 gives vector=0xAC. Assert reset mid-handshake → no vec_valid, IMR reads 0xFFFF.
